// File: rtl/bus_mem_ws.sv
// rtl/bus_mem_ws.sv - wait-state bus memory model with mirroring and write protect
module bus_mem_ws #(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    MEM_ADDR_BITS = 11,
  parameter logic [ADDR_WIDTH-1:0] WP_BASE       = 16'h8000,
  parameter int                    WAIT_STATES   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rw,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wp_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  busy,
  output logic                  wp_err,
  output logic [7:0]            wp_count
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("bus_mem_ws: WAIT_STATES must be within 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [3:0]               wait_cnt;
  logic [ADDR_WIDTH-1:0]    addr_l;
  logic                     rw_l;
  logic [DATA_WIDTH-1:0]    data_l;
  logic [MEM_ADDR_BITS-1:0] mem_idx;
  logic                     write_blocked;

  logic [DATA_WIDTH-1:0] memory [0:(2**MEM_ADDR_BITS)-1];

  // Upper address bits are dropped so the array repeats across the bus space.
  assign mem_idx       = addr_l[MEM_ADDR_BITS-1:0];
  assign write_blocked = wp_en && (addr_l >= WP_BASE);

  // State register; reset abandons any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: requests are only looked at in IDLE, so anything presented mid-access is dropped.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_next = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request capture, wait countdown and registered completion outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      wp_err   <= 1'b0;
      wp_count <= 8'h00;
      wait_cnt <= 4'd0;
      addr_l   <= '0;
      rw_l     <= 1'b0;
      data_l   <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_l   <= addr;
            rw_l     <= rw;
            data_l   <= data_in;
            busy     <= 1'b1;
            wait_cnt <= 4'(WAIT_STATES);
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        S_DONE: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          if (rw_l) begin
            data_out <= memory[mem_idx];
          end else begin
            data_out <= '0;
            if (write_blocked) begin
              wp_err <= 1'b1;
              if (wp_count != 8'hFF) begin
                wp_count <= wp_count + 8'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Array write port; contents survive reset so preloaded images stay put.
  always_ff @(posedge clock) begin
    if (!reset && state == S_DONE && !rw_l && !write_blocked) begin
      memory[mem_idx] <= data_l;
    end
  end

endmodule
